// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle instr memory: request in T reaches decode in T+2, 1/cycle steady state.
// Credit-gated requests never overflow the buffer; optional IFETCH_PERF_CNT_EN adds fetch/drop counters.
module instr_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_instr,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [31:0]           pc_o
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           drop_cnt_o
`endif
);

  localparam int          PW     = $clog2(FIFO_DEPTH);
  localparam int          CW     = PW + 1;
  localparam logic [31:0] PC_RST = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           infl_pc_q, infl_pc_d;
  logic                  out_q, out_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [31:0]           fb_pc_q [FIFO_DEPTH];
  logic [31:0]           fb_pc_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fb_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fb_instr_d [FIFO_DEPTH];
  logic                  pop, push, credit;
  logic [CW:0]           occ;

  always_comb begin
    pop        = (cnt_q != '0) & instr_ready_i;
    push       = mem_rvalid & ~redirect_valid;
    // Slots still claimed after this cycle's pop: in-flight read plus buffered words.
    occ        = (CW+1)'(out_q) + (CW+1)'(cnt_q) - (CW+1)'(pop);
    credit     = occ < (CW+1)'(FIFO_DEPTH);
    mem_rd_req = (state_q == RUN) & fetch_en & ~redirect_valid & credit;

    state_d    = fetch_en ? RUN : IDLE;
    out_d      = mem_rd_req;
    infl_pc_d  = mem_rd_req ? pc_q : infl_pc_q;

    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & 32'hFFFF_FFFC;
    else if (mem_rd_req) pc_d = pc_q + 32'd4;

    fb_pc_d    = fb_pc_q;
    fb_instr_d = fb_instr_q;
    if (push) begin
      fb_pc_d[wr_q]    = infl_pc_q;
      fb_instr_d[wr_q] = mem_instr;
    end

    if (redirect_valid) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RST;
      infl_pc_q  <= '0;
      out_q      <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fb_pc_q    <= '{default: '0};
      fb_instr_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_pc_q  <= infl_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fb_pc_q    <= fb_pc_d;
      fb_instr_q <= fb_instr_d;
    end
  end

  assign mem_addr      = pc_q[ADDR_WIDTH+1:2];
  assign instr_valid_o = cnt_q != '0;
  assign instr_o       = fb_instr_q[rd_q];
  assign pc_o          = fb_pc_q[rd_q];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  // Drops at a redirect: entries left after the concurrent pop, plus the discarded return.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    if (redirect_valid) drop_sum = drop_sum + 33'(cnt_q) - 33'(pop) + 33'(mem_rvalid);
    drop_cnt_d  = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    fetch_cnt_d = fetch_cnt_q;
    if (pop && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: per-cycle vector table plus a PC scoreboard on the decode side.
module tb_instr_fetch_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_instr;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [DW-1:0] instr_o;
  logic [31:0]   pc_o;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]   fetch_cnt_o, drop_cnt_o;
  int            m_fetch, m_drop;
`endif

  instr_fetch_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_instr(mem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // 1-cycle-latency instruction memory
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_instr  <= '0;
    end else begin
      mem_rvalid <= mem_rd_req;
      mem_instr  <= mem_word(mem_addr);
    end
  end

  typedef struct {
    logic        rst, en, rdy, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [9:0]  e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_pc;
  logic [31:0] exp_head;
  int          chk = 0;
  int          err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, en, rdy, redir, input logic [31:0] rpc,
                     input logic e_req, input logic [9:0] e_addr,
                     input logic e_vld, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  initial begin
    // rst en rdy redir rpc | req addr vld pc
    add(1,0,0,0,0,            0,10'h000,0,0);
    add(0,1,1,0,0,            0,10'h000,0,0);
    add(0,1,1,0,0,            1,10'h000,0,0);
    add(0,1,1,0,0,            1,10'h001,0,0);
    add(0,1,1,0,0,            1,10'h002,1,32'h0);
    add(0,1,1,0,0,            1,10'h003,1,32'h4);
    add(0,1,1,0,0,            1,10'h004,1,32'h8);
    // stall with ready low for 10 cycles
    add(1,0,0,0,0,            0,10'h000,0,0);
    add(0,1,0,0,0,            0,10'h000,0,0);
    add(0,1,0,0,0,            1,10'h000,0,0);
    add(0,1,0,0,0,            1,10'h001,0,0);
    for (int k = 0; k < 7; k++) add(0,1,0,0,0, 0,10'h002,1,32'h0);
    add(0,1,1,0,0,            1,10'h002,1,32'h0);
    add(0,1,1,0,0,            1,10'h003,1,32'h4);
    add(0,1,1,0,0,            1,10'h004,1,32'h8);
    add(0,1,1,0,0,            1,10'h005,1,32'hC);
    // redirects: with pop in R, then with stall and in-flight return
    add(0,1,0,0,0,            0,10'h006,1,32'h10);
    add(0,1,1,1,32'h40,       0,10'h006,1,32'h10);
    add(0,1,1,0,0,            1,10'h010,0,0);
    add(0,1,1,0,0,            1,10'h011,0,0);
    add(0,1,1,0,0,            1,10'h012,1,32'h40);
    add(0,1,0,1,32'h103,      0,10'h013,1,32'h44);
    add(0,1,1,0,0,            1,10'h040,0,0);
    add(0,1,1,0,0,            1,10'h041,0,0);
    add(0,1,1,0,0,            1,10'h042,1,32'h100);
    // fetch_en low during a read, then resume
    add(0,0,1,0,0,            0,10'h043,1,32'h104);
    add(0,0,1,0,0,            0,10'h043,1,32'h108);
    add(0,0,1,0,0,            0,10'h043,0,0);
    add(0,1,1,0,0,            0,10'h043,0,0);
    add(0,1,1,0,0,            1,10'h043,0,0);
    add(0,1,1,0,0,            1,10'h044,0,0);
    add(0,1,1,0,0,            1,10'h045,1,32'h10C);
    // redirect to top of address space, wrap
    add(0,1,1,1,32'hFFFF_FFFC,0,10'h046,1,32'h110);
    add(0,1,1,0,0,            1,10'h3FF,0,0);
    add(0,1,1,0,0,            1,10'h000,0,0);
    add(0,1,1,0,0,            1,10'h001,1,32'hFFFF_FFFC);
    add(0,1,1,0,0,            1,10'h002,1,32'h0);
    // redirect coinciding with fetch_en fall
    add(0,0,1,1,32'h200,      0,10'h003,1,32'h4);
    add(0,0,1,0,0,            0,10'h080,0,0);
    add(0,1,1,0,0,            0,10'h080,0,0);
    add(0,1,1,0,0,            1,10'h080,0,0);
    add(0,1,1,0,0,            1,10'h081,0,0);
    add(0,1,1,0,0,            1,10'h082,1,32'h200);
    // reset mid-operation, restart and drain
    add(1,0,0,0,0,            0,10'h000,0,0);
    add(0,1,1,0,0,            0,10'h000,0,0);
    add(0,1,1,0,0,            1,10'h000,0,0);
    add(0,0,1,0,0,            0,10'h001,0,0);
    add(0,0,1,0,0,            0,10'h001,1,32'h0);
    add(0,0,1,0,0,            0,10'h001,0,0);

    ref_pc = 32'h0;
`ifdef IFETCH_PERF_CNT_EN
    m_fetch = 0;
    m_drop  = 0;
`endif

    #2;
    check("rst_req",   32'(mem_rd_req),    32'h0);
    check("rst_addr",  32'(mem_addr),      32'h0);
    check("rst_vld",   32'(instr_valid_o), 32'h0);
    check("rst_instr", instr_o,            32'h0);
    check("rst_pc",    pc_o,               32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n          = ~tbl[i].rst;
      fetch_en       = tbl[i].en;
      instr_ready_i  = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);

      check($sformatf("r%0d_req", i),  32'(mem_rd_req),    32'(tbl[i].e_req));
      check($sformatf("r%0d_addr", i), 32'(mem_addr),      32'(tbl[i].e_addr));
      check($sformatf("r%0d_vld", i),  32'(instr_valid_o), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check($sformatf("r%0d_pc", i),    pc_o,    tbl[i].e_pc);
        check($sformatf("r%0d_instr", i), instr_o, mem_word(tbl[i].e_pc[11:2]));
      end

      if (!rst_n) begin
        exp_q.delete();
        ref_pc = 32'h0;
`ifdef IFETCH_PERF_CNT_EN
        m_fetch = 0;
        m_drop  = 0;
`endif
      end
`ifdef IFETCH_PERF_CNT_EN
      check($sformatf("r%0d_fetch_cnt", i), fetch_cnt_o, 32'(m_fetch));
      check($sformatf("r%0d_drop_cnt", i),  drop_cnt_o,  32'(m_drop));
`endif
      if (rst_n) begin
        if (instr_valid_o && instr_ready_i) begin
          if (exp_q.size() == 0) begin
            check($sformatf("r%0d_sb_underflow", i), pc_o, 32'hDEAD_BEEF);
          end else begin
            exp_head = exp_q.pop_front();
            check($sformatf("r%0d_sb_pc", i), pc_o, exp_head);
          end
`ifdef IFETCH_PERF_CNT_EN
          m_fetch++;
`endif
        end
        if (redirect_valid) begin
`ifdef IFETCH_PERF_CNT_EN
          m_drop += exp_q.size();
`endif
          exp_q.delete();
        end
        if (mem_rd_req) begin
          check($sformatf("r%0d_sb_addr", i), 32'(mem_addr), {22'd0, ref_pc[11:2]});
          exp_q.push_back(ref_pc);
          ref_pc = ref_pc + 32'd4;
        end
        if (redirect_valid) ref_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
